// File: rtl/car_collision_pkg.sv
// Shared geometry, defaults and FSM state type for the frog/car collision checker.
package car_collision_pkg;

  localparam int unsigned XW              = 10;
  localparam int unsigned NumCars         = 8;
  localparam int unsigned CarW            = 32;
  localparam int unsigned FrogW           = 16;
  localparam int unsigned LaneH           = 32;
  localparam int unsigned LaneY0          = 64;
  localparam int unsigned LanePitch       = 48;
  localparam int unsigned DefStartLives   = 3;
  localparam int unsigned DefInvulnFrames = 60;

  typedef enum logic [1:0] {
    StAlive,
    StScan,
    StHold,
    StOver
  } state_e;

  function automatic logic [XW-1:0] lane_top(logic [2:0] lane);
    return XW'(LaneY0) + XW'(LanePitch) * XW'(lane);
  endfunction

endpackage

// File: rtl/car_collision_if.sv
// Bundle between car mover / frog controller (master) and the collision checker (slave).
interface car_collision_if
  import car_collision_pkg::*;
;
  logic                          frame_tick;
  logic                          restart;
  logic [NumCars-1:0][XW-1:0]    car_x;
  logic [XW-1:0]                 frog_x;
  logic [XW-1:0]                 frog_y;
  logic                          hit;
  logic                          respawn;
  logic                          invuln;
  logic [1:0]                    lives;
  logic                          game_over;

  modport master (
    output frame_tick, restart, car_x, frog_x, frog_y,
    input  hit, respawn, invuln, lives, game_over
  );

  modport slave (
    input  frame_tick, restart, car_x, frog_x, frog_y,
    output hit, respawn, invuln, lives, game_over
  );
endinterface

// File: rtl/car_collision_hit_cmp.sv
// Combinational overlap of one car against the frog; all differences wrap mod 1024.
module car_collision_hit_cmp
  import car_collision_pkg::*;
(
  input  logic [XW-1:0] car_x_i,
  input  logic [XW-1:0] frog_x_i,
  input  logic [XW-1:0] frog_y_i,
  input  logic [2:0]    lane_i,
  output logic          hit_o
);
  logic [XW-1:0] dx_fc, dx_cf, dy;

  always_comb begin
    dx_fc = frog_x_i - car_x_i;
    dx_cf = car_x_i - frog_x_i;
    dy    = frog_y_i - lane_top(lane_i);
    hit_o = ((dx_fc < XW'(CarW)) || (dx_cf < XW'(FrogW))) && (dy < XW'(LaneH));
  end
endmodule

// File: rtl/car_collision.sv
// Per-frame snapshot and sequential 8-car scan; owns lives, hit/respawn, invulnerability.
module car_collision
  import car_collision_pkg::*;
#(
  parameter int unsigned StartLives   = DefStartLives,
  parameter int unsigned InvulnFrames = DefInvulnFrames
) (
  input logic            clk,
  input logic            rst_n,
  car_collision_if.slave bus
);
  localparam int unsigned CntW = $clog2(InvulnFrames + 1);

  state_e                      state_q, state_d;
  logic [NumCars-1:0][XW-1:0]  car_q, car_d;
  logic [XW-1:0]               frog_x_q, frog_x_d, frog_y_q, frog_y_d;
  logic [3:0]                  idx_q, idx_d;
  logic                        any_hit_q, any_hit_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [1:0]                  lives_q, lives_d;
  logic                        hit_q, hit_d, respawn_q, respawn_d;
  logic                        invuln_q, invuln_d, over_q, over_d;
  logic                        car_hit;

  car_collision_hit_cmp u_hit_cmp (
    .car_x_i  (car_q[idx_q[2:0]]),
    .frog_x_i (frog_x_q),
    .frog_y_i (frog_y_q),
    .lane_i   (idx_q[2:0]),
    .hit_o    (car_hit)
  );

  always_comb begin
    state_d   = state_q;
    car_d     = car_q;
    frog_x_d  = frog_x_q;
    frog_y_d  = frog_y_q;
    idx_d     = idx_q;
    any_hit_d = any_hit_q;
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    invuln_d  = invuln_q;
    over_d    = over_q;
    hit_d     = 1'b0;
    respawn_d = 1'b0;

    if (bus.restart) begin
      lives_d   = 2'(StartLives);
      over_d    = 1'b0;
      invuln_d  = 1'b0;
      respawn_d = 1'b1;
      state_d   = StAlive;
    end else begin
      unique case (state_q)
        StAlive: begin
          if (bus.frame_tick) begin
            car_d     = bus.car_x;
            frog_x_d  = bus.frog_x;
            frog_y_d  = bus.frog_y;
            any_hit_d = 1'b0;
            idx_d     = 4'd0;
            state_d   = StScan;
          end
        end
        StScan: begin
          // idx 0..7 compares one car per clock; idx 8 is the evaluation edge.
          if (idx_q[3]) begin
            if (any_hit_q) begin
              hit_d = 1'b1;
              if (lives_q == 2'd1) begin
                lives_d = 2'd0;
                over_d  = 1'b1;
                state_d = StOver;
              end else begin
                lives_d   = lives_q - 2'd1;
                respawn_d = 1'b1;
                invuln_d  = 1'b1;
                cnt_d     = CntW'(InvulnFrames);
                state_d   = StHold;
              end
            end else begin
              state_d = StAlive;
            end
          end else begin
            any_hit_d = any_hit_q | car_hit;
            idx_d     = idx_q + 4'd1;
          end
        end
        StHold: begin
          if (bus.frame_tick) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              invuln_d = 1'b0;
              state_d  = StAlive;
            end
          end
        end
        StOver: ;
        default: state_d = StAlive;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAlive;
      car_q     <= '0;
      frog_x_q  <= '0;
      frog_y_q  <= '0;
      idx_q     <= '0;
      any_hit_q <= 1'b0;
      cnt_q     <= '0;
      lives_q   <= 2'(StartLives);
      hit_q     <= 1'b0;
      respawn_q <= 1'b0;
      invuln_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      car_q     <= car_d;
      frog_x_q  <= frog_x_d;
      frog_y_q  <= frog_y_d;
      idx_q     <= idx_d;
      any_hit_q <= any_hit_d;
      cnt_q     <= cnt_d;
      lives_q   <= lives_d;
      hit_q     <= hit_d;
      respawn_q <= respawn_d;
      invuln_q  <= invuln_d;
      over_q    <= over_d;
    end
  end

  assign bus.hit       = hit_q;
  assign bus.respawn   = respawn_q;
  assign bus.invuln    = invuln_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_car_collision.sv
// Directed and randomized checks of car_collision against a frame-level behavioural model.
module tb_car_collision;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  car_collision_if bus ();

  car_collision #(
    .StartLives   (3),
    .InvulnFrames (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  int unsigned car[8];
  int unsigned fx, fy;
  int  m_lives;
  bit  m_over, m_invuln;
  int  m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".lives"}, 32'(bus.lives), 32'(m_lives));
    check({tag, ".invuln"}, 32'(bus.invuln), 32'(m_invuln));
    check({tag, ".game_over"}, 32'(bus.game_over), 32'(m_over));
  endtask

  task automatic apply();
    for (int l = 0; l < 8; l++) bus.car_x[l] = 10'(car[l]);
    bus.frog_x = 10'(fx);
    bus.frog_y = 10'(fy);
  endtask

  // Rectangles overlap if frog is within a car's span on a ring of 1024 pixels.
  function automatic bit model_overlap();
    for (int l = 0; l < 8; l++) begin
      int unsigned ly = 64 + 48 * l;
      int unsigned dy = (fy + 1024 - ly) % 1024;
      int unsigned d1 = (fx + 1024 - car[l]) % 1024;
      int unsigned d2 = (car[l] + 1024 - fx) % 1024;
      if (dy < 32 && (d1 < 32 || d2 < 16)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_frame(input string tag);
    bit ov, eh, er;
    apply();
    ov = model_overlap();
    eh = 1'b0;
    er = 1'b0;
    if (!m_over) begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_invuln = 1'b0;
      end else if (ov) begin
        eh = 1'b1;
        if (m_lives == 1) begin
          m_lives = 0;
          m_over  = 1'b1;
        end else begin
          m_lives--;
          er       = 1'b1;
          m_invuln = 1'b1;
          m_hold   = 2;
        end
      end
    end
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check({tag, ".hit"}, 32'(bus.hit), 32'(k == 9 && eh));
      check({tag, ".respawn"}, 32'(bus.respawn), 32'(k == 9 && er));
    end
    check_state(tag);
  endtask

  task automatic do_restart(input string tag);
    m_lives  = 3;
    m_over   = 1'b0;
    m_invuln = 1'b0;
    m_hold   = 0;
    @(negedge clk) bus.restart = 1'b1;
    @(negedge clk) bus.restart = 1'b0;
    check({tag, ".respawn"}, 32'(bus.respawn), 32'd1);
    check({tag, ".hit"}, 32'(bus.hit), 32'd0);
    check_state(tag);
    @(negedge clk);
    check({tag, ".respawn_end"}, 32'(bus.respawn), 32'd0);
  endtask

  task automatic set_lane0(input int unsigned cx, input int unsigned x, input int unsigned y);
    for (int l = 0; l < 8; l++) car[l] = 500;
    car[0] = cx;
    fx = x;
    fy = y;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.restart    = 1'b0;
    for (int l = 0; l < 8; l++) car[l] = 0;
    fx = 0;
    fy = 0;
    apply();
    m_lives  = 3;
    m_over   = 1'b0;
    m_invuln = 1'b0;
    m_hold   = 0;

    // Reset state and idle frames with the frog outside every lane.
    #12;
    check("reset.hit", 32'(bus.hit), 32'd0);
    check("reset.respawn", 32'(bus.respawn), 32'd0);
    check_state("reset");
    @(negedge clk) rst_n = 1'b1;
    run_frame("idle0");
    run_frame("idle1");

    // Lane 2 hit with frog inside the car span.
    for (int l = 0; l < 8; l++) car[l] = 700;
    car[2] = 100;
    fx = 110;
    fy = 160;
    run_frame("lane2");
    check("lane2.lives_const", 32'(bus.lives), 32'd2);
    check("lane2.invuln_const", 32'(bus.invuln), 32'd1);

    // Horizontal/vertical boundaries on lane 0.
    do_restart("rs_a");
    set_lane0(100, 131, 64); run_frame("edge131");
    do_restart("rs_b");
    set_lane0(100, 132, 64); run_frame("edge132");
    set_lane0(100, 85, 64);  run_frame("edge85");
    do_restart("rs_c");
    set_lane0(100, 84, 64);  run_frame("edge84");
    set_lane0(100, 110, 96); run_frame("edge_y96");
    check("edge.lives_const", 32'(bus.lives), 32'd3);

    // Car straddling 1023->0.
    set_lane0(1010, 5, 64);  run_frame("wrap");
    check("wrap.lives_const", 32'(bus.lives), 32'd2);

    // Held overlap all the way to game over.
    do_restart("rs_d");
    set_lane0(100, 110, 64);
    run_frame("go_h1");
    run_frame("go_w1");
    check("go_w1.invuln_const", 32'(bus.invuln), 32'd1);
    run_frame("go_w2");
    check("go_w2.invuln_const", 32'(bus.invuln), 32'd0);
    run_frame("go_h2");
    run_frame("go_w3");
    run_frame("go_w4");
    run_frame("go_h3");
    check("go.lives_const", 32'(bus.lives), 32'd0);
    check("go.over_const", 32'(bus.game_over), 32'd1);
    run_frame("go_idle1");
    run_frame("go_idle2");
    do_restart("rs_e");
    check("rs_e.lives_const", 32'(bus.lives), 32'd3);

    // Reset dropped mid-scan with overlap present.
    apply();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_lives  = 3;
    m_over   = 1'b0;
    m_invuln = 1'b0;
    m_hold   = 0;
    check("rstscan.hit", 32'(bus.hit), 32'd0);
    check_state("rstscan");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rstscan.hit_after", 32'(bus.hit), 32'd0);
    end
    check_state("rstscan_after");

    // Restart mid-scan abandons the scan.
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    do_restart("rsscan");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rsscan.hit_after", 32'(bus.hit), 32'd0);
    end
    check_state("rsscan_after");

    // Randomized frames, biased toward near-misses and hits.
    for (int i = 0; i < 40; i++) begin
      if (m_over) do_restart("rnd_rs");
      for (int l = 0; l < 8; l++) car[l] = $urandom_range(0, 1023);
      if ($urandom_range(0, 1) == 1) begin
        int unsigned ln;
        ln = $urandom_range(0, 7);
        fy = 64 + 48 * ln + $urandom_range(0, 40);
        fx = (car[ln] + 1024 + $urandom_range(0, 63) - 24) % 1024;
      end else begin
        fx = $urandom_range(0, 1023);
        fy = $urandom_range(0, 1023);
      end
      run_frame("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
